// File: rtl/csa_pkg.sv
// csa_pkg: shared defaults and FSM encoding for the carry-save resolver.
package csa_pkg;
    localparam int W_DEF = 64;
    localparam int CHUNK_DEF = 16;
    localparam int NCHUNK_DEF = (W_DEF + CHUNK_DEF) / CHUNK_DEF;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;
endpackage

// File: rtl/csa_resolver_chunk_adder.sv
// chunk_adder: combinational CHUNK-bit adder with carry in and carry out.
module chunk_adder #(
    parameter int CHUNK = 16
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] s,
    output logic             cout
);
    assign {cout, s} = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};
endmodule

// File: rtl/csa_resolver.sv
// csa_resolver: resolves a carry-save pair to binary, CHUNK bits per cycle.
module csa_resolver
    import csa_pkg::*;
#(
    parameter int W = W_DEF,
    parameter int CHUNK = CHUNK_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W:0]   sum_in,
    input  logic [W:0]   carry_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W+1:0] result,
    output logic         fmt_err
);
    localparam int NCHUNK = (W + CHUNK) / CHUNK;
    localparam int EW = NCHUNK * CHUNK;
    localparam int IW = NCHUNK > 1 ? $clog2(NCHUNK) : 1;

    state_t state, state_nxt;
    logic [IW-1:0] idx;
    logic cy, cout, last;
    logic [EW-1:0] a_q, b_q;
    logic [CHUNK-1:0] s;
    logic [W+1:0] wr, nb;

    assign last = idx == IW'(NCHUNK - 1);
    assign in_ready = state == IDLE;
    assign out_valid = state == DONE;

    chunk_adder #(.CHUNK(CHUNK)) u_add (
        .a(a_q[idx*CHUNK +: CHUNK]),
        .b(b_q[idx*CHUNK +: CHUNK]),
        .cin(cy),
        .s(s),
        .cout(cout)
    );

    // Per-bit write enables: the current chunk, or the final carry when it lands beyond the chunks.
    for (genvar i = 0; i < W + 2; i++) begin : g_wr
        localparam int K = i / CHUNK;
        assign wr[i] = K < NCHUNK ? int'(idx) == K : last;
        assign nb[i] = K < NCHUNK ? s[i % CHUNK] : cout;
    end

    always_comb begin
        state_nxt = state;
        if (state == IDLE) state_nxt = in_valid ? BUSY : IDLE;
        else if (state == BUSY) state_nxt = last ? DONE : BUSY;
        else if (state == DONE) state_nxt = out_ready ? IDLE : DONE;
        else state_nxt = IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            idx <= '0;
            cy <= 1'b0;
            a_q <= '0;
            b_q <= '0;
            result <= '0;
            fmt_err <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && in_valid) begin
                a_q <= EW'(sum_in);
                b_q <= EW'(carry_in);
                idx <= '0;
                cy <= 1'b0;
                result <= '0;
                fmt_err <= sum_in[W] | carry_in[0];
            end else if (state == BUSY) begin
                idx <= last ? '0 : idx + IW'(1);
                cy <= cout;
                result <= (result & ~wr) | (nb & wr);
            end
        end
    end
endmodule

// File: tb/tb_csa_resolver.sv
// tb_csa_resolver: randomized and directed checks of csa_resolver against an arithmetic model.
module tb_csa_resolver;
    localparam int W = 64;
    localparam int CHUNK = 16;
    localparam int NCH = (W + 1 + CHUNK - 1) / CHUNK;

    logic clk = 1'b0;
    logic rst, in_valid, in_ready, out_valid, out_ready, fmt_err;
    logic [W:0] sum_in, carry_in;
    logic [W+1:0] result;
    int checks = 0;
    int failures = 0;

    csa_resolver #(.W(W), .CHUNK(CHUNK)) dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .sum_in(sum_in),
        .carry_in(carry_in),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .result(result),
        .fmt_err(fmt_err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

    function automatic logic [W+1:0] ref_sum(input logic [W:0] s, input logic [W:0] c);
        return {1'b0, s} + {1'b0, c};
    endfunction

    function automatic logic ref_fmt(input logic [W:0] s, input logic [W:0] c);
        return s[W] | c[0];
    endfunction

    // Drives one pair from a negedge in IDLE; returns at a negedge with latency in edges after acceptance.
    task automatic run_op(input logic [W:0] s, input logic [W:0] c, input logic bp,
                          output logic [W+1:0] res, output logic fe, output int lat);
        sum_in = s;
        carry_in = c;
        in_valid = 1'b1;
        out_ready = !bp;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 50) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        if (!out_valid) lat = -1;
        res = result;
        fe = fmt_err;
        if (!bp) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        sum_in = '0;
        carry_in = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_hs in_ready=%b out_valid=%b want 1 0", in_ready, out_valid);
        end
        checks++;
        if (result !== '0 || fmt_err !== 1'b0) begin
            failures++;
            $display("FAIL reset_data result=%h fmt_err=%b want 0 0", result, fmt_err);
        end
    endtask

    task automatic test_directed();
        logic [W:0] sv [4];
        logic [W:0] cv [4];
        logic [W+1:0] want [4];
        logic [W+1:0] res;
        logic fe;
        int lat;
        sv[0] = '0;                              cv[0] = '0;
        want[0] = '0;
        sv[1] = 65'h0_FFFF_FFFF_FFFF_FFFF;       cv[1] = 65'h2;
        want[1] = 66'h1_0000_0000_0000_0001;
        sv[2] = 65'h0_FFFF_FFFF_FFFF_FFFF;       cv[2] = 65'h1_FFFF_FFFF_FFFF_FFFE;
        want[2] = 66'h2_FFFF_FFFF_FFFF_FFFD;
        sv[3] = 65'h1_FFFF_FFFF_FFFF_FFFF;       cv[3] = 65'h1_FFFF_FFFF_FFFF_FFFF;
        want[3] = 66'h3_FFFF_FFFF_FFFF_FFFE;
        for (int i = 0; i < 4; i++) begin
            run_op(sv[i], cv[i], 1'b0, res, fe, lat);
            checks++;
            if (lat !== NCH) begin
                failures++;
                $display("FAIL dir%0d_latency got=%0d want=%0d", i, lat, NCH);
            end
            checks++;
            if (res !== want[i] || res !== ref_sum(sv[i], cv[i])) begin
                failures++;
                $display("FAIL dir%0d_result got=%h want=%h", i, res, want[i]);
            end
            checks++;
            if (fe !== ref_fmt(sv[i], cv[i])) begin
                failures++;
                $display("FAIL dir%0d_fmt got=%b want=%b", i, fe, ref_fmt(sv[i], cv[i]));
            end
        end
    endtask

    task automatic test_backpressure();
        logic [W:0] s1, c1, s2, c2;
        logic [W+1:0] res;
        logic fe;
        int lat;
        s1 = 65'h0_1234_5678_9ABC_DEF0;
        c1 = 65'h0_0FED_CBA9_8765_4320;
        s2 = 65'h0_0000_0000_0000_0007;
        c2 = 65'h0_0000_0000_0000_0008;
        run_op(s1, c1, 1'b1, res, fe, lat);
        checks++;
        if (lat !== NCH || res !== ref_sum(s1, c1)) begin
            failures++;
            $display("FAIL bp_first lat=%0d result=%h want %0d %h", lat, res, NCH, ref_sum(s1, c1));
        end
        sum_in = s2;
        carry_in = c2;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || result !== ref_sum(s1, c1)) begin
                failures++;
                $display("FAIL bp_hold%0d out_valid=%b in_ready=%b result=%h want 1 0 %h",
                         i, out_valid, in_ready, result, ref_sum(s1, c1));
            end
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL bp_release out_valid=%b in_ready=%b want 0 1", out_valid, in_ready);
        end
        run_op(s2, c2, 1'b0, res, fe, lat);
        checks++;
        if (lat !== NCH || res !== ref_sum(s2, c2) || fe !== 1'b0) begin
            failures++;
            $display("FAIL bp_held_pair lat=%0d result=%h fmt=%b want %0d %h 0",
                     lat, res, fe, NCH, ref_sum(s2, c2));
        end
    endtask

    task automatic test_reset_busy();
        int rises;
        sum_in = 65'h1_AAAA_5555_AAAA_5555;
        carry_in = 65'h0_1111_2222_3333_4445;
        in_valid = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL rb_busy in_ready=%b out_valid=%b want 0 0", in_ready, out_valid);
        end
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || result !== '0 || fmt_err !== 1'b0) begin
            failures++;
            $display("FAIL rb_after in_ready=%b out_valid=%b result=%h fmt=%b want 1 0 0 0",
                     in_ready, out_valid, result, fmt_err);
        end
        rises = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (out_valid) rises++;
        end
        checks++;
        if (rises !== 0) begin
            failures++;
            $display("FAIL rb_no_valid out_valid_cycles=%0d want 0", rises);
        end
    endtask

    task automatic test_fmt();
        logic [W:0] sv [3];
        logic [W:0] cv [3];
        logic [W+1:0] res;
        logic fe;
        int lat;
        sv[0] = 65'h1_0000_0000_0000_0000;  cv[0] = '0;
        sv[1] = 65'h0_0000_0000_0000_0010;  cv[1] = 65'h0_0000_0000_0000_0020;
        sv[2] = 65'h0_0000_0000_0000_0003;  cv[2] = 65'h0_0000_0000_0000_0001;
        for (int i = 0; i < 3; i++) begin
            run_op(sv[i], cv[i], 1'b0, res, fe, lat);
            checks++;
            if (res !== ref_sum(sv[i], cv[i]) || fe !== ref_fmt(sv[i], cv[i]) || lat !== NCH) begin
                failures++;
                $display("FAIL fmt%0d result=%h fmt=%b lat=%0d want %h %b %0d",
                         i, res, fe, lat, ref_sum(sv[i], cv[i]), ref_fmt(sv[i], cv[i]), NCH);
            end
        end
        checks++;
        if (ref_sum(sv[0], cv[0]) !== 66'h1_0000_0000_0000_0000) begin
            failures++;
            $display("FAIL fmt_model got=%h want 10000000000000000", ref_sum(sv[0], cv[0]));
        end
    endtask

    task automatic test_back_to_back();
        logic [W:0] s, c;
        logic [W+1:0] res;
        logic fe;
        int lat;
        int bad = 0;
        for (int i = 0; i < 60; i++) begin
            s = 65'({$urandom(), $urandom(), $urandom()});
            c = 65'({$urandom(), $urandom(), $urandom()});
            case ($urandom_range(0, 4))
                0: begin s[W] = 1'b0; c[0] = 1'b0; end
                1: begin s = '1; s[W] = 1'b0; end
                2: c = '0;
                default: ;
            endcase
            run_op(s, c, 1'b0, res, fe, lat);
            checks++;
            if (res !== ref_sum(s, c) || fe !== ref_fmt(s, c) || lat !== NCH) begin
                failures++;
                bad++;
                if (bad < 6)
                    $display("FAIL rand%0d s=%h c=%h result=%h fmt=%b lat=%0d want %h %b %0d",
                             i, s, c, res, fe, lat, ref_sum(s, c), ref_fmt(s, c), NCH);
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_busy();
        test_fmt();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
